// File: rtl/sr_latch_bank_if.sv
// Bus bundle for sr_latch_bank: set/reset requests in, stored state and conflict status out.
interface sr_latch_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr_conflict;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] conflict;
    logic [CNT_W-1:0] conflict_cnt;

    // Event sources / consumers drive requests and observe state
    modport master (
        output s,
        output r,
        output clr_conflict,
        input  q,
        input  qbar,
        input  conflict,
        input  conflict_cnt
    );

    // The storage bank itself
    modport slave (
        input  s,
        input  r,
        input  clr_conflict,
        output q,
        output qbar,
        output conflict,
        output conflict_cnt
    );

endinterface

// File: rtl/sr_latch_bank.sv
// WIDTH-channel clocked set/reset storage bank with input synchronisers,
// parameterised S=R=1 resolution, sticky conflict flags and a saturating
// conflict-cycle counter.
module sr_latch_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      MODE        = 0,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    sr_latch_bank_if.slave  bus
);

    localparam int unsigned MODE_RESET_DOM = 0;
    localparam int unsigned MODE_SET_DOM   = 1;
    localparam int unsigned MODE_HOLD      = 2;
    localparam int unsigned MODE_TOGGLE    = 3;
    localparam int unsigned RST_STAGES     = 2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Unsupported resolution modes are rejected at elaboration
    generate
        if (MODE > MODE_TOGGLE) begin : g_bad_mode
            $error("sr_latch_bank: MODE must be 0..3");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset conditioning: assert asynchronously, release on a clock edge
    // ------------------------------------------------------------------
    logic [RST_STAGES-1:0] rst_pipe_q;
    logic [RST_STAGES-1:0] rst_pipe_d;
    logic                  core_rst;

    // Shift zeros in once the external reset has been removed
    always_comb begin
        rst_pipe_d = {rst_pipe_q[RST_STAGES-2:0], 1'b0};
    end

    // Reset release pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe_q <= '1;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign core_rst = rst_pipe_q[RST_STAGES-1];

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ss_c;
    logic [WIDTH-1:0] rs_c;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign ss_c = bus.s;
            assign rs_c = bus.r;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] s_pipe_q;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] s_pipe_d;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] r_pipe_q;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] r_pipe_d;

            // Each stage takes the previous one; stage 0 takes the raw input
            always_comb begin
                s_pipe_d    = s_pipe_q;
                r_pipe_d    = r_pipe_q;
                s_pipe_d[0] = bus.s;
                r_pipe_d[0] = bus.r;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    s_pipe_d[i] = s_pipe_q[i-1];
                    r_pipe_d[i] = r_pipe_q[i-1];
                end
            end

            // Synchroniser flops, flushed by reset
            always_ff @(posedge clk or posedge core_rst) begin
                if (core_rst) begin
                    s_pipe_q <= '0;
                    r_pipe_q <= '0;
                end else begin
                    s_pipe_q <= s_pipe_d;
                    r_pipe_q <= r_pipe_d;
                end
            end

            assign ss_c = s_pipe_q[SYNC_STAGES-1];
            assign rs_c = r_pipe_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage core and conflict tracking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qbar_q;
    logic [WIDTH-1:0] qbar_d;
    logic [WIDTH-1:0] conflict_q;
    logic [WIDTH-1:0] conflict_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] conf_c;
    logic             any_conf_c;

    assign conf_c     = ss_c & rs_c;
    assign any_conf_c = |conf_c;

    // Per-channel next state with mode-dependent S=R=1 resolution
    always_comb begin
        q_d = q_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            unique case ({ss_c[i], rs_c[i]})
                2'b10: q_d[i] = 1'b1;
                2'b01: q_d[i] = 1'b0;
                2'b11: begin
                    if (MODE == MODE_RESET_DOM) begin
                        q_d[i] = 1'b0;
                    end else if (MODE == MODE_SET_DOM) begin
                        q_d[i] = 1'b1;
                    end else if (MODE == MODE_HOLD) begin
                        q_d[i] = q_q[i];
                    end else begin
                        q_d[i] = ~q_q[i];
                    end
                end
                default: q_d[i] = q_q[i];
            endcase
        end
        qbar_d = ~q_d;
    end

    // Sticky flags and saturating counter; a fresh conflict beats a same-edge clear
    always_comb begin
        conflict_d = conflict_q | conf_c;
        cnt_d      = cnt_q;
        if (bus.clr_conflict) begin
            conflict_d = conf_c;
            cnt_d      = any_conf_c ? CNT_W'(1) : '0;
        end else if (any_conf_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Core state registers
    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            q_q        <= INIT;
            qbar_q     <= ~INIT;
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            qbar_q     <= qbar_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.q            = q_q;
    assign bus.qbar         = qbar_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed and model-checked bench for sr_latch_bank: four resolution modes
// with two-stage synchronisers, plus an unsynchronised instance with INIT=AA.
module tb_sr_latch_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s   = 8'h00;
    logic [7:0] r   = 8'h00;
    logic       clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_latch_bank_if #(.WIDTH(8), .CNT_W(4)) if_m0 ();
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(4)) if_m1 ();
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(4)) if_m2 ();
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(4)) if_m3 ();
    sr_latch_bank_if #(.WIDTH(8), .CNT_W(4)) if_z  ();

    assign if_m0.s = s;  assign if_m0.r = r;  assign if_m0.clr_conflict = clr;
    assign if_m1.s = s;  assign if_m1.r = r;  assign if_m1.clr_conflict = clr;
    assign if_m2.s = s;  assign if_m2.r = r;  assign if_m2.clr_conflict = clr;
    assign if_m3.s = s;  assign if_m3.r = r;  assign if_m3.clr_conflict = clr;
    assign if_z.s  = s;  assign if_z.r  = r;  assign if_z.clr_conflict  = clr;

    sr_latch_bank #(.WIDTH(8), .MODE(0), .SYNC_STAGES(2), .INIT(8'h00), .CNT_W(4))
        u_m0 (.clk(clk), .rst(rst), .bus(if_m0));
    sr_latch_bank #(.WIDTH(8), .MODE(1), .SYNC_STAGES(2), .INIT(8'h00), .CNT_W(4))
        u_m1 (.clk(clk), .rst(rst), .bus(if_m1));
    sr_latch_bank #(.WIDTH(8), .MODE(2), .SYNC_STAGES(2), .INIT(8'h00), .CNT_W(4))
        u_m2 (.clk(clk), .rst(rst), .bus(if_m2));
    sr_latch_bank #(.WIDTH(8), .MODE(3), .SYNC_STAGES(2), .INIT(8'h00), .CNT_W(4))
        u_m3 (.clk(clk), .rst(rst), .bus(if_m3));
    sr_latch_bank #(.WIDTH(8), .MODE(0), .SYNC_STAGES(0), .INIT(8'hAA), .CNT_W(4))
        u_z  (.clk(clk), .rst(rst), .bus(if_z));

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] mq;
        logic [7:0] mc;
        logic [7:0] nq;
        logic [7:0] nc;
        logic [3:0] mcnt;
        logic [3:0] ncnt;
        logic       any;

        // Power-on reset values
        rst = 1'b1;
        step(2);
        chk("por_q",     if_m0.q,    8'h00);
        chk("por_qbar",  if_m0.qbar, 8'hFF);
        chk("por_z_q",   if_z.q,     8'hAA);
        chk("por_z_qbar",if_z.qbar,  8'h55);
        rst = 1'b0;
        step(4);

        // Reset asserted mid-run acts without a clock edge
        s = 8'hFF;
        step(4);
        chk("run_q",    if_m0.q, 8'hFF);
        chk("run_z_q",  if_z.q,  8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q",        if_m0.q,                8'h00);
        chk("mid_rst_qbar",     if_m0.qbar,             8'hFF);
        chk("mid_rst_conflict", if_m0.conflict,         8'h00);
        chk("mid_rst_cnt",      8'(if_m0.conflict_cnt), 8'h00);
        chk("mid_rst_z_q",      if_z.q,                 8'hAA);
        chk("mid_rst_z_qbar",   if_z.qbar,              8'h55);
        s = 8'h00;
        step(1);
        rst = 1'b0;
        step(4);
        chk("post_rst_q",   if_m0.q, 8'h00);
        chk("post_rst_z_q", if_z.q,  8'hAA);

        // Synchroniser latency: one-cycle set pulse, then reset pulse
        s = 8'h01;
        step(1);
        chk("z_set_1edge", if_z.q,  8'hAB);
        chk("lat_set_k",   if_m0.q, 8'h00);
        s = 8'h00;
        step(1);
        chk("lat_set_k1",  if_m0.q, 8'h00);
        step(1);
        chk("lat_set_k2",  if_m0.q, 8'h01);
        chk("lat_set_qbar",if_m0.qbar, 8'hFE);
        step(3);
        chk("set_hold",    if_m0.q, 8'h01);
        r = 8'h01;
        step(1);
        chk("z_rst_1edge", if_z.q,  8'hAA);
        r = 8'h00;
        step(1);
        chk("lat_rst_k1",  if_m0.q, 8'h01);
        step(1);
        chk("lat_rst_k2",  if_m0.q, 8'h00);

        // Resolution modes with s=r=0F held over q=F0
        s = 8'hF0;
        r = 8'h0F;
        step(1);
        s = 8'h00;
        r = 8'h00;
        step(3);
        chk("m0_pre", if_m0.q, 8'hF0);
        chk("m1_pre", if_m1.q, 8'hF0);
        chk("m2_pre", if_m2.q, 8'hF0);
        chk("m3_pre", if_m3.q, 8'hF0);
        s = 8'h0F;
        r = 8'h0F;
        step(2);
        chk("m3_before_core", if_m3.q, 8'hF0);
        step(1);
        chk("m0_conf",      if_m0.q,    8'hF0);
        chk("m1_conf",      if_m1.q,    8'hFF);
        chk("m1_conf_qbar", if_m1.qbar, 8'h00);
        chk("m2_conf",      if_m2.q,    8'hF0);
        chk("m3_conf_a",    if_m3.q,    8'hFF);
        chk("m3_conf_qbar", if_m3.qbar, 8'h00);
        step(1);
        chk("m3_conf_b",    if_m3.q,    8'hF0);
        chk("m1_conf_hold", if_m1.q,    8'hFF);
        step(1);
        chk("m3_conf_c",    if_m3.q,    8'hFF);
        s = 8'h00;
        r = 8'h00;
        step(3);
        chk("m3_final",     if_m3.q,                8'hFF);
        chk("m0_final",     if_m0.q,                8'hF0);
        chk("mode_conflict",if_m0.conflict,         8'h0F);
        chk("mode_cnt",     8'(if_m0.conflict_cnt), 8'h05);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("mode_clr_conflict", if_m0.conflict,         8'h00);
        chk("mode_clr_cnt",      8'(if_m0.conflict_cnt), 8'h00);

        // Conflict flags, counting and saturation
        s = 8'h81;
        r = 8'h81;
        step(3);
        s = 8'h00;
        r = 8'h00;
        step(3);
        chk("conf3_flags", if_m0.conflict,         8'h81);
        chk("conf3_cnt",   8'(if_m0.conflict_cnt), 8'h03);
        s = 8'h81;
        r = 8'h81;
        step(20);
        s = 8'h00;
        r = 8'h00;
        step(3);
        chk("conf_sat_cnt",  8'(if_m0.conflict_cnt), 8'h0F);
        chk("conf_sat_m3",   8'(if_m3.conflict_cnt), 8'h0F);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_flags", if_m0.conflict,         8'h00);
        chk("clr_cnt",   8'(if_m0.conflict_cnt), 8'h00);

        // Clear colliding with a conflict reaching the core
        s = 8'h02;
        r = 8'h02;
        step(1);
        s = 8'h00;
        r = 8'h00;
        step(1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("collide_flags", if_m0.conflict,         8'h02);
        chk("collide_cnt",   8'(if_m0.conflict_cnt), 8'h01);
        step(1);
        chk("collide_cnt_hold", 8'(if_m0.conflict_cnt), 8'h01);

        // Unsynchronised instance against a reference model
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);
        mq   = 8'hAA;
        mc   = 8'h00;
        mcnt = 4'd0;
        chk("rand_start_q", if_z.q, mq);
        for (int k = 0; k < 1000; k++) begin
            s   = 8'($urandom) & 8'($urandom);
            r   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 8; i++) begin
                if (s[i] && r[i])      nq[i] = 1'b0;
                else if (s[i])         nq[i] = 1'b1;
                else if (r[i])         nq[i] = 1'b0;
                else                   nq[i] = mq[i];
            end
            any = ((s & r) != 8'h00);
            nc  = clr ? (s & r) : (mc | (s & r));
            if (clr)                     ncnt = any ? 4'd1 : 4'd0;
            else if (any && mcnt != 4'd15) ncnt = mcnt + 4'd1;
            else                         ncnt = mcnt;
            step(1);
            mq   = nq;
            mc   = nc;
            mcnt = ncnt;
            chk("rand_q",        if_z.q,                mq);
            chk("rand_qbar",     if_z.qbar,             ~mq);
            chk("rand_conflict", if_z.conflict,         mc);
            chk("rand_cnt",      8'(if_z.conflict_cnt), 8'(mcnt));
        end
        s   = 8'h00;
        r   = 8'h00;
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
